dmac_aw_issuer: RTL and testbench

Downstream consumer of the DMAC request arbiter. Takes the arbitrated 32-bit write-request word (valid/ready), decodes it into an AXI write-address beat, and holds it on the AW channel until accepted. Tracks outstanding writes by counting B responses, throttles the arbiter once MAX_OUTSTANDING is reached, and records sticky error status from BRESP.

---
 rtl/dmac_aw_issuer.sv | 102 ++++++++++
 tb/tb_dmac_aw_issuer.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/dmac_aw_issuer.sv
// AXI write-address issuer behind the DMAC request arbiter: one-deep AW holding
// register, outstanding-write credit counter driven by B responses, sticky BRESP error.
module dmac_aw_issuer #(
    parameter int DATA_SIZE       = 32,
    parameter int ADDR_WIDTH      = DATA_SIZE,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  src_valid_i,
    output logic                  src_ready_o,
    input  logic [DATA_SIZE-1:0]  src_data_i,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic [3:0]            awlen_o,
    output logic [2:0]            awsize_o,
    output logic [1:0]            awburst_o,
    input  logic                  bvalid_i,
    input  logic [1:0]            bresp_i,
    output logic                  bready_o,
    output logic [CNT_W-1:0]      outstanding_o,
    output logic                  idle_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);

    typedef enum logic {EMPTY, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             b_hs;

    // bresp_i[0] only distinguishes OKAY/EXOKAY and SLVERR/DECERR pairs; not needed.
    logic unused_bresp0;
    assign unused_bresp0 = bresp_i[0];

    // The holding register frees up in the same cycle the slave takes the beat,
    // so a new word can replace it without a bubble.
    assign src_ready_o = !rst && (cnt < MAX_CNT) && (state == EMPTY || awready_i);
    assign accept      = src_valid_i && src_ready_o;
    assign bready_o    = (cnt != '0);
    assign b_hs        = bvalid_i && bready_o;

    assign awsize_o      = 3'b010;
    assign awburst_o     = 2'b01;
    assign outstanding_o = cnt;
    assign idle_o        = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            awvalid_o <= 1'b0;
            awaddr_o  <= '0;
            awlen_o   <= '0;
            cnt       <= '0;
            err_o     <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state     <= HOLD;
                        awvalid_o <= 1'b1;
                        awaddr_o  <= {src_data_i[DATA_SIZE-1:4], 4'b0000};
                        awlen_o   <= src_data_i[3:0];
                    end
                end
                HOLD: begin
                    if (awready_i) begin
                        if (accept) begin
                            awaddr_o <= {src_data_i[DATA_SIZE-1:4], 4'b0000};
                            awlen_o  <= src_data_i[3:0];
                        end else begin
                            state     <= EMPTY;
                            awvalid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= EMPTY;
                    awvalid_o <= 1'b0;
                end
            endcase

            if (accept && !b_hs)
                cnt <= cnt + CNT_W'(1);
            else if (!accept && b_hs)
                cnt <= cnt - CNT_W'(1);

            // A fresh error outranks a clear landing in the same cycle.
            if (b_hs && bresp_i[1])
                err_o <= 1'b1;
            else if (err_clr_i)
                err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmac_aw_issuer.sv
// Directed bench for dmac_aw_issuer: issue, back-to-back, backpressure, credits, errors, reset.
module tb_dmac_aw_issuer;

    logic        clk = 1'b0;
    logic        rst;
    logic        src_valid_i;
    logic        src_ready_o;
    logic [31:0] src_data_i;
    logic        awvalid_o;
    logic        awready_i;
    logic [31:0] awaddr_o;
    logic [3:0]  awlen_o;
    logic [2:0]  awsize_o;
    logic [1:0]  awburst_o;
    logic        bvalid_i;
    logic [1:0]  bresp_i;
    logic        bready_o;
    logic [2:0]  outstanding_o;
    logic        idle_o;
    logic        err_o;
    logic        err_clr_i;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    dmac_aw_issuer dut (
        .clk(clk), .rst(rst),
        .src_valid_i(src_valid_i), .src_ready_o(src_ready_o), .src_data_i(src_data_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .bvalid_i(bvalid_i), .bresp_i(bresp_i), .bready_o(bready_o),
        .outstanding_o(outstanding_o), .idle_o(idle_o),
        .err_o(err_o), .err_clr_i(err_clr_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Outputs are examined 1 time unit after the rising edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1; src_valid_i = 1'b0; src_data_i = '0; awready_i = 1'b0;
        bvalid_i = 1'b0; bresp_i = 2'b00; err_clr_i = 1'b0;
        tick(); tick();

        // reset state
        chk("rst_awvalid", 32'(awvalid_o), 32'd0);
        chk("rst_awaddr", awaddr_o, 32'd0);
        chk("rst_awlen", 32'(awlen_o), 32'd0);
        chk("rst_outst", 32'(outstanding_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_bready", 32'(bready_o), 32'd0);
        chk("rst_srcrdy", 32'(src_ready_o), 32'd0);
        chk("awsize", 32'(awsize_o), 32'd2);
        chk("awburst", 32'(awburst_o), 32'd1);
        rst = 1'b0; settle();
        chk("srcrdy_after_rst", 32'(src_ready_o), 32'd1);

        // single request
        src_valid_i = 1'b1; src_data_i = 32'h1000_0013; awready_i = 1'b1; settle();
        chk("single_srcrdy", 32'(src_ready_o), 32'd1);
        tick(); src_valid_i = 1'b0;
        chk("single_awvalid", 32'(awvalid_o), 32'd1);
        chk("single_awaddr", awaddr_o, 32'h1000_0010);
        chk("single_awlen", 32'(awlen_o), 32'd3);
        chk("single_outst", 32'(outstanding_o), 32'd1);
        chk("single_bready", 32'(bready_o), 32'd1);
        chk("single_idle", 32'(idle_o), 32'd0);
        tick();
        chk("single_aw_drop", 32'(awvalid_o), 32'd0);
        bvalid_i = 1'b1; bresp_i = 2'b00;
        tick(); bvalid_i = 1'b0;
        chk("single_b_outst", 32'(outstanding_o), 32'd0);
        chk("single_b_idle", 32'(idle_o), 32'd1);
        chk("single_b_err", 32'(err_o), 32'd0);

        // back-to-back, fill credits
        src_valid_i = 1'b1; awready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            src_data_i = 32'h2000_0000 | (32'(i) << 4) | 32'(i);
            tick();
            chk("b2b_awvalid", 32'(awvalid_o), 32'd1);
            chk("b2b_awaddr", awaddr_o, 32'h2000_0000 | (32'(i) << 4));
            chk("b2b_awlen", 32'(awlen_o), 32'(i));
        end
        src_data_i = 32'h2000_0045; settle();
        chk("full_outst", 32'(outstanding_o), 32'd4);
        chk("full_srcrdy", 32'(src_ready_o), 32'd0);
        tick();
        chk("full_aw_drop", 32'(awvalid_o), 32'd0);
        chk("full_outst2", 32'(outstanding_o), 32'd4);
        bvalid_i = 1'b1; settle();
        chk("no_bypass_srcrdy", 32'(src_ready_o), 32'd0);
        tick(); bvalid_i = 1'b0; src_valid_i = 1'b0; settle();
        chk("credit_srcrdy", 32'(src_ready_o), 32'd1);
        chk("credit_outst", 32'(outstanding_o), 32'd3);
        chk("credit_awvalid", 32'(awvalid_o), 32'd0);
        bvalid_i = 1'b1;
        tick(); tick(); tick(); bvalid_i = 1'b0;
        chk("drain_idle", 32'(idle_o), 32'd1);

        // AW backpressure
        awready_i = 1'b0; src_valid_i = 1'b1; src_data_i = 32'h3000_0042;
        tick();
        src_data_i = 32'h3000_0085;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("bp_srcrdy", 32'(src_ready_o), 32'd0);
            chk("bp_awvalid", 32'(awvalid_o), 32'd1);
            chk("bp_awaddr", awaddr_o, 32'h3000_0040);
            chk("bp_awlen", 32'(awlen_o), 32'd2);
            if (i < 4) tick();
        end
        awready_i = 1'b1; settle();
        chk("bp_release_srcrdy", 32'(src_ready_o), 32'd1);
        tick(); src_valid_i = 1'b0;
        chk("bp_second_awvalid", 32'(awvalid_o), 32'd1);
        chk("bp_second_awaddr", awaddr_o, 32'h3000_0080);
        chk("bp_second_awlen", 32'(awlen_o), 32'd5);
        chk("bp_outst", 32'(outstanding_o), 32'd2);
        tick();
        chk("bp_aw_drop", 32'(awvalid_o), 32'd0);

        // simultaneous accept and B at cnt=2
        src_valid_i = 1'b1; src_data_i = 32'h4000_0007; bvalid_i = 1'b1; bresp_i = 2'b00;
        tick(); src_valid_i = 1'b0; bvalid_i = 1'b0;
        chk("simul_outst", 32'(outstanding_o), 32'd2);
        chk("simul_awaddr", awaddr_o, 32'h4000_0000);
        chk("simul_awlen", 32'(awlen_o), 32'd7);
        tick();

        // error handling
        bvalid_i = 1'b1; bresp_i = 2'b10;
        tick();
        chk("err_set", 32'(err_o), 32'd1);
        chk("err_outst", 32'(outstanding_o), 32'd1);
        bresp_i = 2'b00;
        tick(); bvalid_i = 1'b0;
        chk("err_sticky", 32'(err_o), 32'd1);
        chk("err_outst0", 32'(outstanding_o), 32'd0);
        src_valid_i = 1'b1; src_data_i = 32'h5000_0000;
        tick(); tick(); src_valid_i = 1'b0;
        tick();
        chk("err_refill", 32'(outstanding_o), 32'd2);
        bvalid_i = 1'b1; bresp_i = 2'b11; err_clr_i = 1'b1;
        tick(); bvalid_i = 1'b0;
        chk("err_set_wins", 32'(err_o), 32'd1);
        tick(); err_clr_i = 1'b0;
        chk("err_cleared", 32'(err_o), 32'd0);
        bvalid_i = 1'b1; bresp_i = 2'b01;
        tick();
        chk("exokay_no_err", 32'(err_o), 32'd0);
        chk("exokay_outst", 32'(outstanding_o), 32'd0);
        bresp_i = 2'b10; settle();
        chk("cnt0_bready", 32'(bready_o), 32'd0);
        tick(); bvalid_i = 1'b0;
        chk("cnt0_b_ignored_err", 32'(err_o), 32'd0);
        chk("cnt0_b_ignored_outst", 32'(outstanding_o), 32'd0);

        // reset mid-operation
        src_valid_i = 1'b1; src_data_i = 32'h6000_0011;
        tick(); tick(); tick();
        src_valid_i = 1'b0; awready_i = 1'b0;
        chk("pre_rst_outst", 32'(outstanding_o), 32'd3);
        chk("pre_rst_awvalid", 32'(awvalid_o), 32'd1);
        rst = 1'b1; settle();
        chk("in_rst_srcrdy", 32'(src_ready_o), 32'd0);
        tick(); rst = 1'b0; bvalid_i = 1'b1; bresp_i = 2'b10; settle();
        chk("mid_rst_awvalid", 32'(awvalid_o), 32'd0);
        chk("mid_rst_outst", 32'(outstanding_o), 32'd0);
        chk("mid_rst_bready", 32'(bready_o), 32'd0);
        chk("mid_rst_idle", 32'(idle_o), 32'd1);
        tick(); bvalid_i = 1'b0;
        chk("late_b_outst", 32'(outstanding_o), 32'd0);
        chk("late_b_err", 32'(err_o), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
